// File: rtl/apb_arb_master.sv
// apb_arb_master: two-requester round-robin APB master, one transfer in flight.
// Build option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles.
// Ports:
//   pclk, prst        clock, async active-low reset
//   reqN/wrN/addrN/wdataN  command port of requester N (N=0,1)
//   doneN, err        completion pulse per requester, timeout flag with done
//   rdata             data of the last completed read
//   busy              high while a transfer is in SETUP or ACCESS
//   psel/penable/pwrite/paddr/pwdata/prdata/pready  APB master side
module apb_arb_master #(
  parameter int ADDR    = 5,
  parameter int DATA    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            prst,
  input  logic            req0,
  input  logic            wr0,
  input  logic [ADDR-1:0] addr0,
  input  logic [DATA-1:0] wdata0,
  input  logic            req1,
  input  logic            wr1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] wdata1,
  output logic            done0,
  output logic            done1,
  output logic [DATA-1:0] rdata,
  output logic            err,
  output logic            busy,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [ADDR-1:0] paddr,
  output logic [DATA-1:0] pwdata,
  input  logic [DATA-1:0] prdata,
  input  logic            pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [ADDR-1:0] paddr_q, paddr_d;
  logic [DATA-1:0] pwdata_q, pwdata_d;
  logic [DATA-1:0] rdata_q, rdata_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic            busy_q, busy_d;
  // last granted requester; also identifies the owner of the
  // transfer in flight, since it updates at grant
  logic            last_q, last_d;
  logic            gnt1;
  logic            expire;

`ifdef APB_TIMEOUT_EN
  localparam int            CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign expire = (cnt_q == CMAX);
  assign err    = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // requester 1 wins if alone, or if both ask and 0 went last
  assign gnt1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    last_d    = last_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          last_d    = gnt1;
          pwrite_d  = gnt1 ? wr1 : wr0;
          paddr_d   = gnt1 ? addr1 : addr0;
          pwdata_d  = gnt1 ? wdata1 : wdata0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        // pready on the expiry cycle counts as a normal completion
        if (pready || expire) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done0_d   = ~last_q;
          done1_d   = last_q;
          if (pready && !pwrite_q) begin
            rdata_d = prdata;
          end
`ifdef APB_TIMEOUT_EN
          err_d     = ~pready;
`endif
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign rdata   = rdata_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: randomized bench for apb_arb_master with a
// register-file slave and a transaction-level reference model.
module tb_apb_arb_master;
  localparam int ADDR = 5;
  localparam int DATA = 32;

  logic            pclk = 1'b0;
  logic            prst;
  logic            req0, wr0, req1, wr1;
  logic [ADDR-1:0] addr0, addr1, paddr;
  logic [DATA-1:0] wdata0, wdata1, pwdata, prdata, rdata;
  logic            done0, done1, err, busy;
  logic            psel, penable, pwrite, pready;

  int nvec = 0;
  int nerr = 0;

  always #5 pclk = ~pclk;

  apb_arb_master #(.ADDR(ADDR), .DATA(DATA), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  function automatic logic [DATA-1:0] init_val(int i);
    return 32'h5A00_0000 | (i * 32'h0001_0203);
  endfunction

  // register-file slave: pready after slv_waits extra cycles
  logic [DATA-1:0] smem [32];
  int              slv_waits = 0;
  bit              slv_stuck = 1'b0;
  int              wcnt;

  assign prdata = smem[paddr];

  always @(posedge pclk or negedge prst) begin
    if (!prst) begin
      pready <= 1'b0;
      wcnt   <= 0;
      for (int i = 0; i < 32; i++) smem[i] <= init_val(i);
    end else begin
      if (psel && penable && pready && pwrite) smem[paddr] <= pwdata;
      if (pready) begin
        pready <= 1'b0;
        wcnt   <= 0;
      end else if (psel && penable && !slv_stuck) begin
        if (wcnt >= slv_waits) begin
          pready <= 1'b1;
          wcnt   <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  // reference model: memory image, last read data, last grant
  logic [DATA-1:0] mmem [32];
  logic [DATA-1:0] m_rdata;
  int              m_last;

  task automatic model_reset();
    m_last  = 1;
    m_rdata = '0;
    for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
  endtask

  task automatic idle_inputs();
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic wait_done(input int maxc, output bit got, output int cyc);
    got = 0;
    cyc = 0;
    while (cyc < maxc && !got) begin
      @(negedge pclk);
      cyc++;
      if (done0 || done1) got = 1;
    end
  endtask

  task automatic wait_psel(input int maxc, output bit got);
    got = 0;
    for (int c = 0; c < maxc && !got; c++) begin
      @(negedge pclk);
      if (psel) got = 1;
    end
  endtask

  task automatic test_reset();
    prst = 1'b1;
    idle_inputs();
    #1 prst = 1'b0;
    #2;
    nvec++;
    if ({psel, penable, pwrite, done0, done1, err, busy} !== 7'b0) begin
      nerr++;
      $display("FAIL rst_ctl got=%b exp=0000000",
               {psel, penable, pwrite, done0, done1, err, busy});
    end
    nvec++;
    if (paddr !== '0 || pwdata !== '0 || rdata !== '0) begin
      nerr++;
      $display("FAIL rst_data paddr=%h pwdata=%h rdata=%h exp=0",
               paddr, pwdata, rdata);
    end
    repeat (2) @(negedge pclk);
    prst = 1'b1;
    model_reset();
    @(negedge pclk);
    nvec++;
    if ({psel, busy, done0, done1} !== 4'b0) begin
      nerr++;
      $display("FAIL rst_idle got=%b exp=0000", {psel, busy, done0, done1});
    end
  endtask

  task automatic test_write();
    slv_waits = 0;
    req0 = 1; wr0 = 1; addr0 = 5'd3; wdata0 = 32'hDEAD_BEEF;
    @(negedge pclk);
    nvec++;
    if (psel !== 1 || penable !== 0 || busy !== 1) begin
      nerr++;
      $display("FAIL wr_setup psel=%b pen=%b busy=%b exp=1,0,1",
               psel, penable, busy);
    end
    nvec++;
    if (paddr !== 5'd3 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1) begin
      nerr++;
      $display("FAIL wr_cmd paddr=%h pwdata=%h pwrite=%b exp=03,deadbeef,1",
               paddr, pwdata, pwrite);
    end
    // command port changes must not disturb the transfer in flight
    addr0 = 5'h1C; wdata0 = $urandom;
    @(negedge pclk);
    nvec++;
    if (psel !== 1 || penable !== 1) begin
      nerr++;
      $display("FAIL wr_access psel=%b pen=%b exp=1,1", psel, penable);
    end
    @(negedge pclk);
    nvec++;
    if (paddr !== 5'd3 || pwdata !== 32'hDEAD_BEEF || done0 !== 0) begin
      nerr++;
      $display("FAIL wr_stable paddr=%h pwdata=%h done0=%b exp=03,deadbeef,0",
               paddr, pwdata, done0);
    end
    @(negedge pclk);
    nvec++;
    if ({done0, done1, err, psel, penable, busy} !== 6'b100000) begin
      nerr++;
      $display("FAIL wr_done got=%b exp=100000",
               {done0, done1, err, psel, penable, busy});
    end
    req0 = 0;
    mmem[3] = 32'hDEAD_BEEF;
    m_last  = 0;
    @(negedge pclk);
    nvec++;
    if (done0 !== 0 || psel !== 0) begin
      nerr++;
      $display("FAIL wr_pulse done0=%b psel=%b exp=0,0", done0, psel);
    end
    nvec++;
    if (smem[3] !== mmem[3]) begin
      nerr++;
      $display("FAIL wr_mem got=%h exp=%h", smem[3], mmem[3]);
    end
  endtask

  task automatic test_read();
    bit got;
    int cyc;
    logic [DATA-1:0] d;
    slv_waits = 2;
    req1 = 1; wr1 = 0; addr1 = 5'd3;
    wait_done(20, got, cyc);
    m_rdata = mmem[3];
    nvec++;
    if (!got || {done1, done0, err} !== 3'b100 || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL rd_done got=%b d1d0e=%b rdata=%h exp=100,%h",
               got, {done1, done0, err}, rdata, m_rdata);
    end
    req1 = 0;
    m_last = 1;
    @(negedge pclk);
    d = $urandom;
    req0 = 1; wr0 = 1; addr0 = 5'd7; wdata0 = d;
    wait_done(20, got, cyc);
    req0 = 0;
    mmem[7] = d;
    m_last = 0;
    nvec++;
    if (!got || done0 !== 1 || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL rd_hold got=%b done0=%b rdata=%h exp=1,%h",
               got, done0, rdata, m_rdata);
    end
    @(negedge pclk);
    nvec++;
    if (smem[7] !== mmem[7]) begin
      nerr++;
      $display("FAIL rd_wmem got=%h exp=%h", smem[7], mmem[7]);
    end
  endtask

  task automatic test_back_to_back();
    bit              got;
    int              cyc;
    int              ex;
    logic            cw [2];
    logic [ADDR-1:0] ca [2];
    logic [DATA-1:0] cd [2];
    for (int r = 0; r < 2; r++) begin
      cw[r] = 1'($urandom_range(0, 1));
      ca[r] = 5'($urandom_range(0, 31));
      cd[r] = $urandom;
    end
    wr0 = cw[0]; addr0 = ca[0]; wdata0 = cd[0];
    wr1 = cw[1]; addr1 = ca[1]; wdata1 = cd[1];
    req0 = 1; req1 = 1;
    for (int t = 0; t < 12; t++) begin
      ex = (m_last == 0) ? 1 : 0;
      slv_waits = $urandom_range(0, 3);
      wait_psel(10, got);
      nvec++;
      if (!got || paddr !== ca[ex] || pwrite !== cw[ex]) begin
        nerr++;
        $display("FAIL rr_cmd t=%0d got=%b paddr=%h pwrite=%b exp=%h,%b",
                 t, got, paddr, pwrite, ca[ex], cw[ex]);
      end
      wait_done(20, got, cyc);
      nvec++;
      if (!got || {done1, done0} !== (ex == 1 ? 2'b10 : 2'b01)) begin
        nerr++;
        $display("FAIL rr_grant t=%0d d1d0=%b exp_req=%0d", t,
                 {done1, done0}, ex);
      end
      nvec++;
      if (psel !== 0 || err !== 0) begin
        nerr++;
        $display("FAIL rr_gap t=%0d psel=%b err=%b exp=0,0", t, psel, err);
      end
      if (cw[ex]) mmem[ca[ex]] = cd[ex];
      else m_rdata = mmem[ca[ex]];
      nvec++;
      if (rdata !== m_rdata) begin
        nerr++;
        $display("FAIL rr_rdata t=%0d got=%h exp=%h", t, rdata, m_rdata);
      end
      m_last = ex;
      cw[ex] = 1'($urandom_range(0, 1));
      ca[ex] = 5'($urandom_range(0, 31));
      cd[ex] = $urandom;
      if (ex == 0) begin
        wr0 = cw[0]; addr0 = ca[0]; wdata0 = cd[0];
      end else begin
        wr1 = cw[1]; addr1 = ca[1]; wdata1 = cd[1];
      end
    end
    req0 = 0; req1 = 0;
    @(negedge pclk);
  endtask

  task automatic test_reset_mid();
    bit got;
    bit any;
    int cyc;
    slv_stuck = 1;
    req0 = 1; wr0 = 1; addr0 = 5'd9; wdata0 = $urandom;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge pclk);
      if (penable) got = 1;
    end
    #2 prst = 1'b0;
    #1;
    nvec++;
    if (!got || {psel, penable, busy, done0, done1, err} !== 6'b0) begin
      nerr++;
      $display("FAIL mid_rst seen=%b got=%b exp=000000", got,
               {psel, penable, busy, done0, done1, err});
    end
    req0 = 0;
    slv_stuck = 0;
    slv_waits = 1;
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b1;
    model_reset();
    any = 0;
    repeat (3) begin
      @(negedge pclk);
      any |= (done0 | done1 | psel);
    end
    nvec++;
    if (any !== 0 || rdata !== '0) begin
      nerr++;
      $display("FAIL mid_nodone activity=%b rdata=%h exp=0,0", any, rdata);
    end
    req0 = 1; wr0 = 0; addr0 = 5'd9;
    req1 = 1; wr1 = 0; addr1 = 5'd4;
    wait_psel(10, got);
    nvec++;
    if (!got || paddr !== 5'd9) begin
      nerr++;
      $display("FAIL mid_first got=%b paddr=%h exp=09", got, paddr);
    end
    wait_done(20, got, cyc);
    req0 = 0;
    m_rdata = mmem[9];
    nvec++;
    if (!got || done0 !== 1 || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL mid_rd0 got=%b done0=%b rdata=%h exp=1,%h",
               got, done0, rdata, m_rdata);
    end
    wait_done(20, got, cyc);
    req1 = 0;
    m_rdata = mmem[4];
    m_last = 1;
    nvec++;
    if (!got || done1 !== 1 || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL mid_rd1 got=%b done1=%b rdata=%h exp=1,%h",
               got, done1, rdata, m_rdata);
    end
    @(negedge pclk);
  endtask

  task automatic test_timeout();
    bit got;
    int cyc;
`ifdef APB_TIMEOUT_EN
    // 16 ACCESS cycles after SETUP: completion seen 18 cycles after request
    slv_stuck = 1;
    req0 = 1; wr0 = 0; addr0 = 5'd5;
    wait_done(40, got, cyc);
    req0 = 0;
    nvec++;
    if (!got || cyc != 18 || {done0, err, busy, psel} !== 4'b1100) begin
      nerr++;
      $display("FAIL to_stuck got=%b cyc=%0d d0/err/busy/psel=%b exp=18,1100",
               got, cyc, {done0, err, busy, psel});
    end
    nvec++;
    if (rdata !== m_rdata) begin
      nerr++;
      $display("FAIL to_rdata got=%h exp=%h", rdata, m_rdata);
    end
    @(negedge pclk);
    nvec++;
    if (err !== 0 || done0 !== 0) begin
      nerr++;
      $display("FAIL to_pulse err=%b done0=%b exp=0,0", err, done0);
    end
    slv_stuck = 0;
    slv_waits = 14;
    req1 = 1; wr1 = 0; addr1 = 5'd6;
    wait_done(40, got, cyc);
    req1 = 0;
    m_rdata = mmem[6];
    nvec++;
    if (!got || cyc != 18 || done1 !== 1 || err !== 0 || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL to_edge cyc=%0d done1=%b err=%b rdata=%h exp=18,1,0,%h",
               cyc, done1, err, rdata, m_rdata);
    end
    @(negedge pclk);
    slv_waits = 15;
    req0 = 1; wr0 = 0; addr0 = 5'd2;
    wait_done(40, got, cyc);
    req0 = 0;
    nvec++;
    if (!got || cyc != 18 || done0 !== 1 || err !== 1 || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL to_late cyc=%0d done0=%b err=%b rdata=%h exp=18,1,1,%h",
               cyc, done0, err, rdata, m_rdata);
    end
    repeat (2) @(negedge pclk);
    slv_waits = 0;
`else
    slv_stuck = 1;
    req0 = 1; wr0 = 0; addr0 = 5'd5;
    wait_done(40, got, cyc);
    nvec++;
    if (got || {busy, psel, penable, err} !== 4'b1110) begin
      nerr++;
      $display("FAIL to_wait done=%b busy/psel/pen/err=%b exp=0,1110",
               got, {busy, psel, penable, err});
    end
    req0 = 0;
    slv_stuck = 0;
    #2 prst = 1'b0;
    @(negedge pclk);
    prst = 1'b1;
    model_reset();
    @(negedge pclk);
    nvec++;
    if (busy !== 0 || psel !== 0) begin
      nerr++;
      $display("FAIL to_recover busy=%b psel=%b exp=0,0", busy, psel);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
